fpwm_spi_master: RTL
====================

# fpwm_spi_master

SPI master that serialises one complete PWM configuration frame (pos compare 0/1, neg compare 0/1, control) into the existing fpwm SPI slave port. It sits in the controller-side logic, driven from the system clock, and owns o_SCK/o_MOSI/o_SS toward the fpwm block. It precedes each frame with a sync pulse so the slave's bit counter always starts from zero, even after an aborted frame.

## Interface
- PWM_WIDTH, 8, width of each configuration word input; must be <= SPI_WIDTH
- SPI_WIDTH, 8, bits per SPI word on the wire
- CLK_DIV, 4, i_Clk cycles per SCK half-period (D); must be >= 1
- i_Clk  input  1  system clock; all state on rising edge
- i_Resetn  input  1  asynchronous, active-low reset
- i_Start  input  1  request a frame; sampled only in IDLE
- i_PosCmp0, i_PosCmp1, i_NegCmp0, i_NegCmp1, i_Control  input  PWM_WIDTH each  words to send
- o_Busy  output  1  frame in progress
- o_Done  output  1  one-cycle pulse at frame end
- o_SCK  output  1  SPI clock, idles low
- o_MOSI  output  1  SPI data, MSB first
- o_SS  output  1  slave select, active low

## Operation
- Reset (async): o_SS=1, o_SCK=0, o_MOSI=0, o_Busy=0, o_Done=0, state IDLE, counters 0.
- IDLE + i_Start=1: latch the five words into a 5*SPI_WIDTH shift register, order pos0, pos1, neg0, neg1, ctrl (pos0 first on wire); each word zero-extended at the MSB side to SPI_WIDTH. Enter SYNC. i_Start in any other state is ignored.
- SYNC: o_SS=1; o_SCK high D cycles, then low D cycles (falling edge with SS high clears slave bit counter).
- SETUP: o_SS=0, o_MOSI=frame MSB, o_SCK=0 for D cycles.
- SHIFT: per bit, o_SCK high D cycles then low D cycles. Slave samples on SCK falling edge. o_MOSI advances to the next bit on the same i_Clk edge that raises o_SCK (bits 2..N), giving D cycles setup and D cycles hold around each falling edge.
- After the falling edge of bit 5*SPI_WIDTH: HOLD, o_SCK=0, o_SS=0, D cycles.
- Then o_SS=1, o_MOSI=0, o_Done=1 for one cycle, o_Busy=0, back to IDLE.
- Exactly 5*SPI_WIDTH SCK falling edges with o_SS=0 per frame; none extra.
- Reset mid-frame: outputs return to reset values immediately; next frame's SYNC pulse resynchronises the slave.

## Timing
- D = CLK_DIV, N = 5*SPI_WIDTH. Start accepted at edge 0.
- Cycles 1..D: SCK high, SS high; D+1..2D: SCK low, SS high.
- Cycle 2D+1: SS falls, MOSI = bit N-1.
- SS low for D + 2D*N cycles (D*(1+2N)); with defaults 4*81 = 324 cycles.
- o_Done and SS rise at cycle 2D + D*(1+2N) + 1; o_Busy high from cycle 1 through the cycle before.
- o_Busy is low in the o_Done cycle; i_Start in that cycle is accepted (back-to-back frames; SS high for 2D+1 cycles minimum between frames).
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package fpwm_pkg: state enum (IDLE, SYNC, SETUP, SHIFT, HOLD, DONE), FRAME_WORDS=5, word-order index constants; shared with fpwm.
- Sub-module fpwm_spi_tick: half-period tick generator, counter width $clog2(CLK_DIV+1), synchronous clear on state change.
- Bit counter width $clog2(5*SPI_WIDTH+1).

## Test plan
- CLK_DIV=2, words 0x10, 0x80, 0x20, 0x90, 0x03 -> SYNC pulse with SS high, SS low 162 cycles, 40 falling edges, bytes captured MSB first equal inputs; o_Done at cycle 167.
- Same frame into fpwm slave model -> pos_compare0=0x10, pos_compare1=0x80, neg_compare0=0x20, neg_compare1=0x90, control=0x03.
- i_Start held high continuously -> frames back-to-back, SS high exactly 2D+1 cycles between them, each frame decodes correctly at the slave.
- i_Start pulsed during SHIFT -> ignored, single o_Done, exactly 40 falling edges.
- i_Resetn low after bit 13 -> SS=1, SCK=0, MOSI=0 same cycle; next frame 0x01..0x05 lands correctly at slave (SYNC cleared partial count).
- PWM_WIDTH=6, SPI_WIDTH=8, i_PosCmp0=6'h3F -> wire byte 0x3F (two leading zeros).

Source files
------------

// File: rtl/fpwm_pkg.sv
// Shared definitions for the fpwm SPI configuration path: transfer state
// encoding and frame word layout.
package fpwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam int FRAME_WORDS = 5;

    // Word slots in transmit order; slot 0 goes out first on the wire.
    localparam int IDX_POS0 = 0;
    localparam int IDX_POS1 = 1;
    localparam int IDX_NEG0 = 2;
    localparam int IDX_NEG1 = 3;
    localparam int IDX_CTRL = 4;

endpackage

// File: rtl/fpwm_spi_tick.sv
// Half-period tick generator: pulses once every CLK_DIV cycles while running,
// held at zero while clear is asserted so the first phase is a full D cycles.
module fpwm_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpwm_spi_master.sv
// SPI master that sends one five-word PWM configuration frame to the fpwm
// slave, preceded by an SS-high SCK pulse that resets the slave bit counter.
module fpwm_spi_master
    import fpwm_pkg::*;
#(
    parameter int PWM_WIDTH = 8,
    parameter int SPI_WIDTH = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Resetn,
    input  logic                 i_Start,
    input  logic [PWM_WIDTH-1:0] i_PosCmp0,
    input  logic [PWM_WIDTH-1:0] i_PosCmp1,
    input  logic [PWM_WIDTH-1:0] i_NegCmp0,
    input  logic [PWM_WIDTH-1:0] i_NegCmp1,
    input  logic [PWM_WIDTH-1:0] i_Control,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_SCK,
    output logic                 o_MOSI,
    output logic                 o_SS
);

    localparam int N  = FRAME_WORDS * SPI_WIDTH;
    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    state_t                       state;
    logic   [N-1:0]               shreg;
    logic   [N-1:0]               frame_load;
    logic   [SPI_WIDTH-1:0]       words [FRAME_WORDS];
    logic   [BW-1:0]              bit_cnt;
    logic                         tick;

    function automatic logic [SPI_WIDTH-1:0] zext(input logic [PWM_WIDTH-1:0] w);
        return SPI_WIDTH'(w);
    endfunction

    always_comb begin
        words[IDX_POS0] = zext(i_PosCmp0);
        words[IDX_POS1] = zext(i_PosCmp1);
        words[IDX_NEG0] = zext(i_NegCmp0);
        words[IDX_NEG1] = zext(i_NegCmp1);
        words[IDX_CTRL] = zext(i_Control);
        frame_load = '0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            frame_load[N-1-i*SPI_WIDTH -: SPI_WIDTH] = words[i];
        end
    end

    fpwm_spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (i_Clk),
        .rst_n(i_Resetn),
        .clear(state == IDLE),
        .tick (tick)
    );

    // Frame data is never reset; it is always reloaded before it is shifted.
    always_ff @(posedge i_Clk) begin
        if (state == IDLE && i_Start) begin
            shreg <= frame_load;
        end else if (state == SHIFT && tick && !o_SCK) begin
            shreg <= {shreg[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_Clk or negedge i_Resetn) begin
        if (!i_Resetn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            o_SCK   <= 1'b0;
            o_MOSI  <= 1'b0;
            o_SS    <= 1'b1;
            o_Busy  <= 1'b0;
            o_Done  <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        bit_cnt <= '0;
                        o_SCK   <= 1'b1;
                        o_Busy  <= 1'b1;
                        state   <= SYNC;
                    end
                end
                SYNC: begin
                    if (tick) begin
                        if (o_SCK) begin
                            o_SCK <= 1'b0;
                        end else begin
                            o_SS   <= 1'b0;
                            o_MOSI <= shreg[N-1];
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        o_SCK <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The first bit is already on MOSI; later bits advance with SCK rising.
                    if (tick) begin
                        if (o_SCK) begin
                            o_SCK   <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                            end
                        end else begin
                            o_SCK  <= 1'b1;
                            o_MOSI <= shreg[N-2];
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        o_SS   <= 1'b1;
                        o_MOSI <= 1'b0;
                        o_Done <= 1'b1;
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
